// File: rtl/pipelined_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_shifter
//
// Pipelined barrel shifter for the execute stage. Performs SLL, SRL, SRA and,
// when the SHIFTER_ROTATE_EN macro is defined, ROR on a WIDTH-bit operand.
// The log-shifter network (LOG2W levels, level k shifts by 2^k) is spread
// over STAGES register stages that all advance together on a single enable.
//
// Build option:
//   SHIFTER_ROTATE_EN  defined   -> op 2'b11 rotates right by the amount
//                      undefined -> no rotate hardware, op 2'b11 acts as SLL
//
// Parameters:
//   WIDTH   operand/result width (power of two, 8..64)
//   STAGES  number of register stages in the network (1..log2(WIDTH))
//   TAG_W   width of the side-band tag
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, clears every stage
//   in_valid   operand/amount/op/tag valid this cycle
//   in_ready   block accepts input this cycle (= pipe advance)
//   in_data    operand to shift
//   in_amt     shift amount, only bits [LOG2W-1:0] are used
//   in_op      00 SLL, 01 SRL, 10 SRA, 11 ROR (or SLL without rotate)
//   in_tag     side-band tag carried unchanged to out_tag
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_data   shifted result
//   out_tag    tag belonging to out_data
// ---------------------------------------------------------------------------
module pipelined_shifter #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LOG2W = $clog2(WIDTH);

  // The whole pipe moves as one: it advances whenever the last stage is
  // empty or being drained. Bubbles are not collapsed.
  logic adv;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // One network level: shift by 2^k according to the operation. SRA keeps
  // the MSB in place at every level, so the fill bit stays the sign of the
  // operand captured at the input.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input int               k
  );
    logic [WIDTH-1:0] r;
    int               sh;
    sh = 1 << k;
    case (op)
      2'b01:   r = d >> sh;
      2'b10:   r = $signed(d) >>> sh;
`ifdef SHIFTER_ROTATE_EN
      2'b11:   r = (d >> sh) | (d << (WIDTH - sh));
`else
      2'b11:   r = d << sh;
`endif
      default: r = d << sh;
    endcase
    return r;
  endfunction

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [WIDTH-1:0] src_data;
    logic [LOG2W-1:0] src_amt;
    logic [1:0]       src_op;
    logic [TAG_W-1:0] src_tag;
    logic             src_valid;
    logic [WIDTH-1:0] nxt_data;

    logic [WIDTH-1:0] q_data;
    logic [LOG2W-1:0] q_amt;
    logic [1:0]       q_op;
    logic [TAG_W-1:0] q_tag;
    logic             q_valid;

    // Stage 0 takes the raw inputs; later stages take the previous register.
    if (s == 0) begin : g_first
      assign src_data  = in_data;
      assign src_amt   = in_amt[LOG2W-1:0];
      assign src_op    = in_op;
      assign src_tag   = in_tag;
      assign src_valid = in_valid;
    end else begin : g_rest
      assign src_data  = g_stage[s-1].q_data;
      assign src_amt   = g_stage[s-1].q_amt;
      assign src_op    = g_stage[s-1].q_op;
      assign src_tag   = g_stage[s-1].q_tag;
      assign src_valid = g_stage[s-1].q_valid;
    end

    // Apply only the levels that belong to this stage, i.e. those with
    // floor(k*STAGES/LOG2W) == s, in increasing order of k.
    always_comb begin
      nxt_data = src_data;
      for (int k = 0; k < LOG2W; k++) begin
        if (((k * STAGES) / LOG2W) == s && src_amt[k]) begin
          nxt_data = shift_level(nxt_data, src_op, k);
        end
      end
    end

    // Stage register: reset wins over advance, otherwise load or hold.
    always_ff @(posedge clk) begin
      if (rst) begin
        q_data  <= '0;
        q_amt   <= '0;
        q_op    <= '0;
        q_tag   <= '0;
        q_valid <= 1'b0;
      end else if (adv) begin
        q_data  <= nxt_data;
        q_amt   <= src_amt;
        q_op    <= src_op;
        q_tag   <= src_tag;
        q_valid <= src_valid;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].q_valid;
  assign out_data  = g_stage[STAGES-1].q_data;
  assign out_tag   = g_stage[STAGES-1].q_tag;

  // Upper amount bits and the control fields of the final stage have no
  // consumer; they are gathered here so the intent is explicit.
  logic unused_bits;
  assign unused_bits = ^{in_amt[WIDTH-1:LOG2W],
                         g_stage[STAGES-1].q_amt,
                         g_stage[STAGES-1].q_op};

endmodule

// File: tb/tb_pipelined_shifter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_shifter
//
// Directed testbench for pipelined_shifter (WIDTH=32, STAGES=2, TAG_W=5).
// Expected results are hand-computed constants. Define SHIFTER_ROTATE_EN for
// both the bench and the design to exercise the rotate build.
// ---------------------------------------------------------------------------
module tb_pipelined_shifter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_amt;
  logic [1:0]  in_op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  int compared;
  int mismatched;

  pipelined_shifter #(
    .WIDTH  (32),
    .STAGES (2),
    .TAG_W  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 unit after the edge before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one input item and clock it in
  task automatic applyStimulus(input logic [31:0] d, input logic [31:0] a,
                               input logic [1:0] op, input logic [4:0] tag);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_op    = op;
    in_tag   = tag;
    tick();
    in_valid = 1'b0;
  endtask

  // One comparison with its own failure accounting
  task automatic checkOutput(input string name, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Check the output handshake, data and tag in one go
  task automatic checkResult(input string name, input logic [31:0] d,
                             input logic [4:0] tag);
    checkOutput({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({name, "_data"}, out_data, d);
    checkOutput({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
  endtask

  localparam logic [31:0] ROR_EXP =
`ifdef SHIFTER_ROTATE_EN
    32'h8000_0000;
`else
    32'h0000_0002;
`endif

  initial begin
    int          sent;
    int          got;
    logic        hold_valid;
    logic [31:0] hold_data;
    logic [4:0]  hold_tag;
    logic [31:0] exp_d;

    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_data    = 32'hDEAD_BEEF;
    in_amt     = 32'd3;
    in_op      = 2'b00;
    in_tag     = 5'd7;
    out_ready  = 1'b1;

    // Reset held two cycles with in_valid high: nothing may appear
    tick();
    checkOutput("rst1_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst1_data", out_data, 32'd0);
    tick();
    checkOutput("rst2_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst2_data", out_data, 32'd0);
    checkOutput("rst2_tag", {27'd0, out_tag}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Basic ops, back to back, latency two cycles
    applyStimulus(32'h8000_00F0, 32'd4, 2'b00, 5'd1);
    checkOutput("lat_not_early", {31'd0, out_valid}, 32'd0);
    applyStimulus(32'h8000_00F0, 32'd4, 2'b01, 5'd2);
    checkResult("sll4", 32'h0000_0F00, 5'd1);
    applyStimulus(32'h8000_00F0, 32'd4, 2'b10, 5'd3);
    checkResult("srl4", 32'h0800_000F, 5'd2);
    tick();
    checkResult("sra4", 32'hF800_000F, 5'd3);
    tick();
    checkOutput("drain_valid", {31'd0, out_valid}, 32'd0);

    // Amount edges and masking
    applyStimulus(32'h8000_00F0, 32'd0, 2'b10, 5'd4);
    applyStimulus(32'h8000_00F0, 32'd31, 2'b10, 5'd5);
    checkResult("amt0", 32'h8000_00F0, 5'd4);
    applyStimulus(32'h8000_00F0, 32'd32, 2'b00, 5'd6);
    checkResult("sra31", 32'hFFFF_FFFF, 5'd5);
    applyStimulus(32'h0000_0001, 32'd1, 2'b11, 5'd7);
    checkResult("sll32", 32'h8000_00F0, 5'd6);
    applyStimulus(32'h8000_0000, 32'd33, 2'b01, 5'd8);
    checkResult("op11", ROR_EXP, 5'd7);
    tick();
    checkResult("srl33", 32'h4000_0000, 5'd8);
    tick();

    // Backpressure: six items, out_ready low for three cycles mid-stream
    sent       = 0;
    got        = 0;
    hold_valid = 1'b0;
    hold_data  = '0;
    hold_tag   = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 6);
      in_data   = 32'd1;
      in_amt    = 32'(sent + 1);
      in_op     = 2'b00;
      in_tag    = 5'(10 + sent);
      #1;
      if (hold_valid) begin
        checkOutput("bp_hold_data", out_data, hold_data);
        checkOutput("bp_hold_tag", {27'd0, out_tag}, {27'd0, hold_tag});
      end
      hold_valid = 1'b0;
      if (out_valid && !out_ready) begin
        checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        hold_valid = 1'b1;
        hold_data  = out_data;
        hold_tag   = out_tag;
      end
      if (out_valid && out_ready) begin
        exp_d = 32'd1 << (got + 1);
        checkOutput("bp_data", out_data, exp_d);
        checkOutput("bp_tag", {27'd0, out_tag}, 32'(10 + got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp_count", 32'(got), 32'd6);
    tick();
    checkOutput("bp_no_dup", {31'd0, out_valid}, 32'd0);

    // Mid-operation reset: both in-flight items must vanish
    applyStimulus(32'h0000_00FF, 32'd4, 2'b00, 5'd20);
    in_valid = 1'b1;
    in_data  = 32'h0000_00FF;
    in_amt   = 32'd8;
    in_op    = 2'b00;
    in_tag   = 5'd21;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checkOutput("mrst_valid0", {31'd0, out_valid}, 32'd0);
    tick();
    checkOutput("mrst_valid1", {31'd0, out_valid}, 32'd0);
    tick();
    checkOutput("mrst_valid2", {31'd0, out_valid}, 32'd0);
    applyStimulus(32'h0000_00FF, 32'd8, 2'b00, 5'd22);
    checkOutput("mrst_lat", {31'd0, out_valid}, 32'd0);
    tick();
    checkResult("mrst_next", 32'h0000_FF00, 5'd22);
    tick();
    checkOutput("mrst_end", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, pipelined barrel shifter for the execute stage: performs SLL, SRL, SRA (and optionally ROR) on a WIDTH-bit operand. The shift network is split into STAGES register stages, with a valid/ready handshake on both sides and a pass-through tag. It replaces the single-cycle left-only shifter on the critical path of the ALU and feeds the writeback mux.

## Interface
- WIDTH, 32: operand/result width; power of two, 8..64. LOG2W = $clog2(WIDTH).
- STAGES, 2: register stages in the shift network; 1..LOG2W.
- TAG_W, 5: width of the side-band tag (destination register index).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand, amount, op and tag valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  WIDTH  operand to shift.
- in_amt  input  WIDTH  shift amount; only bits [LOG2W-1:0] used.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
- in_tag  input  TAG_W  carried unchanged to out_tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the result.

## Operation
- Shift amount = in_amt[LOG2W-1:0]; upper bits ignored (in_amt=33, WIDTH=32 shifts by 1).
- Network: LOG2W levels, level k shifts by 2^k when amount bit k is set. Level k sits in stage floor(k*STAGES/LOG2W); each stage ends in a register holding data, remaining amount bits, op, tag, valid.
- SLL fills zeros at LSB; SRL fills zeros at MSB; SRA fills with in_data[WIDTH-1] captured at input; ROR wraps LSBs to MSB.
- Amount 0 returns in_data unchanged for every op.
- Pipeline is a single-enable pipe: adv = out_ready | ~out_valid. When adv, every stage register loads from the previous stage; stage 0 loads {in_valid, in_*}. When ~adv, all stages hold.
- in_ready = adv (combinational from out_ready and out_valid only; no dependency on in_valid).
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Bubbles travel with the pipe (not collapsed); a stage with valid=0 still advances.
- Results emerge in input order; no drops, no duplicates.

## Timing
- Latency: exactly STAGES cycles from input transfer to out_valid, with continuous out_ready.
- Throughput: one result per cycle when out_ready held high.
- Backpressure: out_ready low with out_valid high freezes the entire pipe; out_data/out_tag stable until transfer.
- Simultaneous in and out transfer in the same cycle is legal and is the steady state.
- Reset: all stage valid bits 0, out_valid 0, out_data 0, out_tag 0; in_ready 1 the cycle after rst deasserts. rst mid-operation discards all in-flight items; nothing is emitted for them.
- rst takes priority over adv.

## Configuration
- SHIFTER_ROTATE_EN defined: op 11 performs rotate right by the amount.
- SHIFTER_ROTATE_EN undefined: no rotate hardware; op 11 is executed as SLL. All other ops identical.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0 throughout; in_ready=1 first cycle after release.
- Basic ops, WIDTH=32 STAGES=2, out_ready=1: in_data=0x8000_00F0, amt=4: SLL->0x0000_0F00, SRL->0x0800_000F, SRA->0xF800_000F, each on out_valid exactly 2 cycles after accept; tags 1,2,3 returned in order.
- Amount masking and edges: amt=0 -> 0x8000_00F0 unchanged; amt=31 SRA -> 0xFFFF_FFFF; amt=32 SLL -> 0x8000_00F0 (treated as 0).
- Backpressure: stream 6 tagged items, drop out_ready for 3 cycles mid-stream -> out_data/out_tag held, in_ready=0 while out_valid=1, all 6 results delivered once, in order.
- Rotate: with SHIFTER_ROTATE_EN, in_data=0x0000_0001, op=11, amt=1 -> 0x8000_0000; without macro same stimulus -> 0x0000_0002.
- Mid-op reset: accept 2 items, assert rst for 1 cycle before either emerges -> neither item ever appears on out_valid; next input after reset returns correctly with latency STAGES.
